half_subtractor: RTL and testbench
==================================

# half_subtractor

Bit-parallel half-subtractor block. It computes per-lane difference (a XOR b) and borrow (NOT a AND b) combinationally, and also provides a registered copy with a valid flag and a saturating borrow-event counter. It serves as a leaf arithmetic primitive. The default WIDTH=1 is the single-bit half subtractor used in unit-level tests. Wider instances feed borrow-chain or compare logic upstream.

## Interface
- WIDTH, 1, number of independent half-subtractor lanes (≥1)
- CNT_W, 16, width of borrow event counter (≥2)

- clk  input  1  rising-edge clock for all registered state
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  minuend bits, lane i uses a[i]
- b  input  WIDTH  subtrahend bits, lane i uses b[i]
- in_valid  input  1  qualifies a/b for the registered path and counter
- clr_cnt  input  1  synchronous clear of borrow_cnt
- diff  output  WIDTH  combinational difference, a ^ b
- bo  output  WIDTH  combinational borrow, ~a & b
- diff_q  output  WIDTH  registered diff
- bo_q  output  WIDTH  registered bo
- out_valid  output  1  diff_q/bo_q hold a newly captured result
- borrow_cnt  output  CNT_W  saturating count of borrow lanes seen

## Operation
- Lanes are fully independent. No borrow propagates between lanes.
- Per lane truth table (a,b -> diff,bo): 0,0->0,0; 0,1->1,1; 1,0->1,0; 1,1->0,0.
- diff and bo are pure combinational functions of a and b. They are unaffected by clk, rst_n, in_valid and clr_cnt.
- Registered path, on each rising clk edge:
  - If in_valid=1: diff_q<=a^b, bo_q<=~a&b, out_valid<=1.
  - If in_valid=0: diff_q and bo_q hold their values, out_valid<=0.
- Counter, on each rising clk edge:
  - If clr_cnt=1: borrow_cnt<=0. Clear has priority over any increment in the same cycle.
  - Else if in_valid=1: borrow_cnt<=min(borrow_cnt + popcount(~a&b), 2^CNT_W−1).
  - Else: hold.
- Saturation: the sum is computed at CNT_W+clog2(WIDTH+1) bits, then clamped. The counter never wraps.
- Inputs X/Z are not handled specially. Behaviour follows plain bitwise operators.

## Timing
- Combinational outputs (diff, bo) have zero-cycle latency. They must settle within the same simulation time step as an a/b change.
- Registered outputs have 1-cycle latency. The inputs sampled at edge N appear on diff_q, bo_q and out_valid after edge N.
- out_valid is a single-cycle pulse per accepted input. There is no backpressure or ready signal.
- borrow_cnt reflects inputs accepted up to and including the previous edge.
- Reset (rst_n=0, asynchronous, applied at any time including mid-stream) forces diff_q=0, bo_q=0, out_valid=0 and borrow_cnt=0 immediately, independent of clk.
- While rst_n=0, registered state holds at reset values and in_valid/clr_cnt are ignored. diff and bo keep tracking a and b.
- Reset deassertion is synchronous to the system. The first capture occurs on the first rising edge with rst_n=1.

## Test plan
- Truth table, WIDTH=1, combinational: drive (a,b) = (0,0), (0,1), (1,0), (1,1) with 5-time-unit spacing. Required diff/bo: 0/0, 1/1, 1/0, 0/0 respectively, with no clock needed.
- Registered path, WIDTH=4: apply a=4'b0011, b=4'b0101 with in_valid=1 for one cycle. After that edge, required diff_q=4'b0110, bo_q=4'b0100, out_valid=1. On the next edge with in_valid=0, required out_valid=0 and diff_q/bo_q unchanged.
- Counter accumulation, WIDTH=4: apply a=0, b=4'hF with in_valid=1 for 3 cycles. Required borrow_cnt=12. Then apply clr_cnt=1 together with in_valid=1 for one cycle; required borrow_cnt=0.
- Saturation, CNT_W=4, WIDTH=4: apply a=0, b=4'hF with in_valid=1 for 5 cycles. Required borrow_cnt sequence 4, 8, 12, 15, 15.
- Async reset mid-stream: with out_valid=1 and borrow_cnt=8, pull rst_n low between clock edges. Required: all registered outputs are 0 immediately, before the next edge, while diff/bo still equal a^b and ~a&b.

Source files
------------

// File: rtl/half_subtractor_if.sv
// Operand/result bundle for the half_subtractor leaf primitive.
// master drives operands and control; slave (the subtractor) returns results.
interface half_subtractor_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             clr_cnt;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bo;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] bo_q;
    logic             out_valid;
    logic [CNT_W-1:0] borrow_cnt;

    modport master (
        output a, b, in_valid, clr_cnt,
        input  diff, bo, diff_q, bo_q, out_valid, borrow_cnt
    );

    modport slave (
        input  a, b, in_valid, clr_cnt,
        output diff, bo, diff_q, bo_q, out_valid, borrow_cnt
    );
endinterface

// File: rtl/half_subtractor.sv
// Bit-parallel half subtractor: combinational diff/borrow per lane, a registered
// copy with a valid pulse, and a saturating count of borrowing lanes.
module half_subtractor #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    half_subtractor_if.slave   bus
);

    localparam int unsigned POP_W = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] bo_c;
    logic [POP_W-1:0] pop_c;
    logic [SUM_W-1:0] sum_c;

    logic [WIDTH-1:0] diff_d,       diff_q;
    logic [WIDTH-1:0] bo_d,         bo_q;
    logic             out_valid_d,  out_valid_q;
    logic [CNT_W-1:0] borrow_cnt_d, borrow_cnt_q;

    // Lane arithmetic and borrow popcount; lanes never interact.
    always_comb begin
        diff_c = bus.a ^ bus.b;
        bo_c   = ~bus.a & bus.b;
        pop_c  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop_c = pop_c + POP_W'(bo_c[i]);
        end
        // Widened sum so the clamp sees the true total rather than a wrapped one.
        sum_c = {{POP_W{1'b0}}, borrow_cnt_q} + {{CNT_W{1'b0}}, pop_c};
    end

    // Next-state for the registered path and the borrow counter.
    always_comb begin
        diff_d       = diff_q;
        bo_d         = bo_q;
        out_valid_d  = 1'b0;
        borrow_cnt_d = borrow_cnt_q;

        if (bus.in_valid) begin
            diff_d      = diff_c;
            bo_d        = bo_c;
            out_valid_d = 1'b1;
        end

        if (bus.clr_cnt) begin
            borrow_cnt_d = '0;
        end else if (bus.in_valid) begin
            if (sum_c > CNT_MAX) begin
                borrow_cnt_d = '1;
            end else begin
                borrow_cnt_d = sum_c[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q       <= '0;
            bo_q         <= '0;
            out_valid_q  <= 1'b0;
            borrow_cnt_q <= '0;
        end else begin
            diff_q       <= diff_d;
            bo_q         <= bo_d;
            out_valid_q  <= out_valid_d;
            borrow_cnt_q <= borrow_cnt_d;
        end
    end

    assign bus.diff       = diff_c;
    assign bus.bo         = bo_c;
    assign bus.diff_q     = diff_q;
    assign bus.bo_q       = bo_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.borrow_cnt = borrow_cnt_q;

endmodule

// File: tb/tb_half_subtractor.sv
// Directed-vector bench for half_subtractor: single-lane, four-lane and a
// narrow-counter instance share one clock and reset.
module tb_half_subtractor;

    logic clk;
    logic rst_n;

    int unsigned n_tests;
    int unsigned n_fail;

    half_subtractor_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    half_subtractor_if #(.WIDTH(4), .CNT_W(16)) if4 ();
    half_subtractor_if #(.WIDTH(4), .CNT_W(4))  ifs ();

    half_subtractor #(.WIDTH(1), .CNT_W(16)) u_hs1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    half_subtractor #(.WIDTH(4), .CNT_W(16)) u_hs4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    half_subtractor #(.WIDTH(4), .CNT_W(4)) u_hss (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifs.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample one time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_in  [4];
    logic [1:0] tt_exp [4];
    logic [3:0] sat_exp [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tt_in[0]  = 2'b00; tt_exp[0] = 2'b00;
        tt_in[1]  = 2'b01; tt_exp[1] = 2'b11;
        tt_in[2]  = 2'b10; tt_exp[2] = 2'b10;
        tt_in[3]  = 2'b11; tt_exp[3] = 2'b00;
        sat_exp[0] = 4'd4; sat_exp[1] = 4'd8; sat_exp[2] = 4'd12;
        sat_exp[3] = 4'd15; sat_exp[4] = 4'd15;

        rst_n = 1'b0;
        if1.a = '0; if1.b = '0; if1.in_valid = 1'b0; if1.clr_cnt = 1'b0;
        if4.a = '0; if4.b = '0; if4.in_valid = 1'b0; if4.clr_cnt = 1'b0;
        ifs.a = '0; ifs.b = '0; ifs.in_valid = 1'b0; ifs.clr_cnt = 1'b0;
        #1;

        check("rst_diff_q",  32'(if4.diff_q),     32'h0);
        check("rst_bo_q",    32'(if4.bo_q),       32'h0);
        check("rst_valid",   32'(if4.out_valid),  32'h0);
        check("rst_cnt",     32'(if4.borrow_cnt), 32'h0);

        // Single-lane truth table while held in reset: no capture, comb tracks a/b.
        if1.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if1.a = tt_in[i][1];
            if1.b = tt_in[i][0];
            #1;
            check($sformatf("tt%0d_diff", i), 32'(if1.diff), 32'(tt_exp[i][1]));
            check($sformatf("tt%0d_bo", i),   32'(if1.bo),   32'(tt_exp[i][0]));
            #4;
        end
        tick();
        check("inrst_valid", 32'(if1.out_valid),  32'h0);
        check("inrst_cnt",   32'(if1.borrow_cnt), 32'h0);
        if1.in_valid = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;

        // Four-lane registered capture.
        if4.a = 4'b0011; if4.b = 4'b0101; if4.in_valid = 1'b1;
        if1.a = 1'b0;    if1.b = 1'b1;    if1.in_valid = 1'b1;
        tick();
        check("reg_diff_q", 32'(if4.diff_q),     32'h6);
        check("reg_bo_q",   32'(if4.bo_q),       32'h4);
        check("reg_valid",  32'(if4.out_valid),  32'h1);
        check("reg_cnt",    32'(if4.borrow_cnt), 32'h1);
        check("w1_diff_q",  32'(if1.diff_q),     32'h1);
        check("w1_bo_q",    32'(if1.bo_q),       32'h1);
        check("w1_cnt",     32'(if1.borrow_cnt), 32'h1);

        @(negedge clk);
        if4.a = 4'hF; if4.b = 4'h0; if4.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        tick();
        check("hold_valid",  32'(if4.out_valid),  32'h0);
        check("hold_diff_q", 32'(if4.diff_q),     32'h6);
        check("hold_bo_q",   32'(if4.bo_q),       32'h4);
        check("hold_cnt",    32'(if4.borrow_cnt), 32'h1);
        check("w1_pulse",    32'(if1.out_valid),  32'h0);

        @(negedge clk);
        if4.clr_cnt = 1'b1;
        tick();
        check("clr_idle_cnt", 32'(if4.borrow_cnt), 32'h0);

        // Accumulate four borrows per cycle.
        @(negedge clk);
        if4.clr_cnt = 1'b0;
        if4.a = 4'h0; if4.b = 4'hF; if4.in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("acc%0d_cnt", i), 32'(if4.borrow_cnt), 32'(4 * i));
        end

        @(negedge clk);
        if4.clr_cnt = 1'b1;
        tick();
        check("clr_prio_cnt",   32'(if4.borrow_cnt), 32'h0);
        check("clr_prio_valid", 32'(if4.out_valid),  32'h1);
        check("clr_prio_bo_q",  32'(if4.bo_q),       32'hF);

        // Mixed lanes: a=1010 b=0110 -> diff=1100 bo=0100.
        @(negedge clk);
        if4.clr_cnt = 1'b0;
        if4.a = 4'b1010; if4.b = 4'b0110;
        tick();
        check("mix_diff", 32'(if4.diff),       32'hC);
        check("mix_bo",   32'(if4.bo),         32'h4);
        check("mix_diff_q", 32'(if4.diff_q),   32'hC);
        check("mix_cnt",  32'(if4.borrow_cnt), 32'h1);

        // Narrow counter saturates at 15.
        @(negedge clk);
        ifs.a = 4'h0; ifs.b = 4'hF; ifs.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat%0d_cnt", i), 32'(ifs.borrow_cnt), 32'(sat_exp[i]));
        end
        @(negedge clk);
        ifs.b = 4'b0001;
        tick();
        check("sat_hold_cnt", 32'(ifs.borrow_cnt), 32'hF);

        // Build out_valid=1 and borrow_cnt=8 on the four-lane instance.
        @(negedge clk);
        ifs.in_valid = 1'b0;
        if4.clr_cnt = 1'b1; if4.in_valid = 1'b0;
        @(negedge clk);
        if4.clr_cnt = 1'b0;
        if4.a = 4'h0; if4.b = 4'hF; if4.in_valid = 1'b1;
        tick();
        tick();
        check("pre_rst_cnt",   32'(if4.borrow_cnt), 32'h8);
        check("pre_rst_valid", 32'(if4.out_valid),  32'h1);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  32'(if4.out_valid),  32'h0);
        check("arst_cnt",    32'(if4.borrow_cnt), 32'h0);
        check("arst_diff_q", 32'(if4.diff_q),     32'h0);
        check("arst_bo_q",   32'(if4.bo_q),       32'h0);
        check("arst_diff",   32'(if4.diff),       32'hF);
        check("arst_bo",     32'(if4.bo),         32'hF);
        check("arst_s_cnt",  32'(ifs.borrow_cnt), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        if4.in_valid = 1'b0;
        tick();
        check("post_rst_valid", 32'(if4.out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
